mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port byte-lane Memory between the instruction-fetch port (F) and the load/store port (D).
//  Arbitrates valid/ready requests and rejects misaligned or illegal accesses before they reach Memory.
//  Drives Memory address/wr_data/wr_mask/rd_mask and routes o_rd_data back to the owning requester.
//  Sits between the core's fetch/LSU stages and Memory; fixed one-cycle request->response latency.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive denied F cycles before F gets priority (1..15)
//  CNT_W         4  width of starvation counter
// PORTS
//  i_clk           in   1   clock, all state on posedge
//  i_reset         in   1   asynchronous reset, active-low
//  i_f_valid       in   1   fetch request valid
//  o_f_ready       out  1   fetch request accepted this cycle
//  i_f_addr        in   32  fetch address (word read, RDMASK_W)
//  o_f_rvalid      out  1   fetch response valid (1-cycle pulse)
//  o_f_rdata       out  32  fetch data, valid when o_f_rvalid
//  o_f_err         out  1   fetch misaligned, qualified by o_f_rvalid
//  i_d_valid       in   1   data request valid
//  o_d_ready       out  1   data request accepted this cycle
//  i_d_addr        in   32  data address
//  i_d_wr_data     in   32  store data
//  i_d_wr_mask     in   2   WRMASK_N/B/H/W
//  i_d_rd_mask     in   3   RDMASK_W/HZ/BZ/HE/BE/XX
//  o_d_rvalid      out  1   data response valid (loads and stores)
//  o_d_rdata       out  32  load data, 0 for stores/errors
//  o_d_err         out  1   misaligned or illegal mask, qualified by o_d_rvalid
//  o_mem_address   out  32  to Memory i_address
//  o_mem_wr_data   out  32  to Memory i_wr_data
//  o_mem_wr_mask   out  2   to Memory i_wr_mask
//  o_mem_rd_mask   out  3   to Memory i_rd_mask
//  i_mem_rd_data   in   32  from Memory o_rd_data
// BEHAVIOUR
//  Reset (i_reset=0, async): rvalid/err/rdata outputs 0, starve counter 0, in-flight tag cleared; mem ports idle.
//  Idle mem drive (no grant): wr_mask=WRMASK_N, rd_mask=RDMASK_XX, address/wr_data=0. Never idle-drive a write.
//  Grant (combinational, same cycle): D has priority unless starve_cnt==STARVE_LIMIT, then F wins.
//  ready: o_x_ready=1 only for the granted requester with valid=1; at most one ready per cycle; no ready while in reset.
//  Accept = valid&&ready; request fields sampled that cycle; the mem ports carry the granted request in that cycle.
//  Starve counter: +1 each cycle F valid and not granted (saturates at STARVE_LIMIT); cleared on F accept or F not valid.
//  Legality (D): rd_mask in 6..7 -> err; wr_mask!=N and rd_mask!=XX together -> err.
//  Alignment: word (W read/write) needs addr[1:0]==0; half (HZ/HE/WRMASK_H) needs addr[0]==0; F needs addr[1:0]==0.
//  Illegal/misaligned accept: ready still 1, mem ports stay idle (no write), response next cycle with err=1, rdata=0.
//  Response: exactly one rvalid pulse, cycle after accept, on the accepting port; tag register records owner/type/err.
//  Load response: rdata=i_mem_rd_data (Memory already extended/lane-selected). Store/XX response: rdata=0, err=0.
//  Back-to-back accepts every cycle allowed; F and D responses never in same cycle.
//  D WRMASK_N and RDMASK_XX together: legal no-op, memory untouched, rvalid with rdata=0.
//  Reset mid-operation: pending response dropped; no rvalid after reset release for pre-reset requests.
// TESTING
//  Reset, both valid=0 -> all rvalid 0, mem wr_mask=0, rd_mask=5.
//  F fetch 0x04 alone -> f_ready same cycle, next cycle f_rvalid=1, rdata=0x0A08FFFF.
//  D store W 0x100=0xDEADBEEF, then D load BE 0x103 -> d_rdata=0xFFFFFFDE, err=0.
//  F and D valid for 6 cycles with STARVE_LIMIT=4 -> D granted 4 cycles, F on 5th, D on 6th.
//  D store H addr 0x101 -> d_rvalid, err=1, memory word 0x100 unchanged on reread.
//  Assert reset between accept and response -> no rvalid pulses for 3 cycles after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, mem_port_arbiter and Memory.
//   f_*   : fetch port (valid/ready request, one-cycle rvalid response)
//   d_*   : load/store port (valid/ready request, one-cycle rvalid response)
//   mem_* : single-port byte-lane Memory drive and read-data return
// Modports: slave = arbiter view; master = requesters plus Memory view.
interface mem_port_arbiter_if;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_addr;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic [1:0]  d_wr_mask;
  logic [2:0]  d_rd_mask;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_wr_mask;
  logic [2:0]  mem_rd_mask;
  logic [31:0] mem_rd_data;

  modport slave (
    input  f_valid, f_addr, d_valid, d_addr, d_wr_data, d_wr_mask, d_rd_mask, mem_rd_data,
    output f_ready, f_rvalid, f_rdata, f_err, d_ready, d_rvalid, d_rdata, d_err,
           mem_address, mem_wr_data, mem_wr_mask, mem_rd_mask
  );
  modport master (
    output f_valid, f_addr, d_valid, d_addr, d_wr_data, d_wr_mask, d_rd_mask, mem_rd_data,
    input  f_ready, f_rvalid, f_rdata, f_err, d_ready, d_rvalid, d_rdata, d_err,
           mem_address, mem_wr_data, mem_wr_mask, mem_rd_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port Memory between fetch (F) and load/store (D).
// D wins by default; F wins once it has been denied STARVE_LIMIT cycles in a row.
// Misaligned/illegal requests are accepted but never reach Memory; they get an
// err response. Every accept gets exactly one rvalid pulse on the next cycle.
// Ports:
//   i_clk   : clock, all state on posedge
//   i_reset : asynchronous reset, active low
//   bus     : mem_port_arbiter_if.slave (F/D request+response, Memory drive/return)
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [1:0] WR_N = 2'd0, WR_H = 2'd2, WR_W = 2'd3;
  localparam logic [2:0] RD_W = 3'd0, RD_HZ = 3'd1, RD_HE = 3'd3, RD_XX = 3'd5;

  // Response tag: who owns next cycle's pulse and whether it returns Memory data.
  typedef struct packed {
    logic vld;
    logic own_f;
    logic load;
    logic err;
  } tag_t;

  logic [CNT_W-1:0] r_starve;
  tag_t             r_tag;
  tag_t             w_tag_nxt;
  logic             w_f_pri, w_gnt_d, w_gnt_f;
  logic             w_d_store, w_d_load, w_d_illegal, w_d_word, w_d_half, w_d_err;
  logic             w_f_err;

  assign w_f_pri = (r_starve == CNT_W'(STARVE_LIMIT));
  // Grants already include valid, so a grant is an accept.
  assign w_gnt_d = i_reset && bus.d_valid && !(w_f_pri && bus.f_valid);
  assign w_gnt_f = i_reset && bus.f_valid && !w_gnt_d;
  assign bus.d_ready = w_gnt_d;
  assign bus.f_ready = w_gnt_f;

  assign w_f_err = (bus.f_addr[1:0] != 2'b00);

  always_comb begin
    w_d_store   = (bus.d_wr_mask != WR_N);
    w_d_load    = !w_d_store && (bus.d_rd_mask != RD_XX);
    w_d_illegal = (bus.d_rd_mask > RD_XX) || (w_d_store && bus.d_rd_mask != RD_XX);
    w_d_word    = (bus.d_wr_mask == WR_W) || (!w_d_store && bus.d_rd_mask == RD_W);
    w_d_half    = (bus.d_wr_mask == WR_H) ||
                  (!w_d_store && (bus.d_rd_mask == RD_HZ || bus.d_rd_mask == RD_HE));
    w_d_err     = w_d_illegal || (w_d_word && bus.d_addr[1:0] != 2'b00) ||
                  (w_d_half && bus.d_addr[0]);
  end

  // Memory sees only legal granted requests; everything else idles (never a write).
  always_comb begin
    bus.mem_address = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_mask = WR_N;
    bus.mem_rd_mask = RD_XX;
    if (w_gnt_d && !w_d_err) begin
      bus.mem_address = bus.d_addr;
      bus.mem_wr_data = bus.d_wr_data;
      bus.mem_wr_mask = bus.d_wr_mask;
      bus.mem_rd_mask = bus.d_rd_mask;
    end else if (w_gnt_f && !w_f_err) begin
      bus.mem_address = bus.f_addr;
      bus.mem_rd_mask = RD_W;
    end
  end

  always_comb begin
    w_tag_nxt       = '0;
    w_tag_nxt.vld   = w_gnt_d || w_gnt_f;
    w_tag_nxt.own_f = w_gnt_f;
    w_tag_nxt.err   = w_gnt_f ? w_f_err : (w_gnt_d && w_d_err);
    w_tag_nxt.load  = w_gnt_f ? !w_f_err : (w_gnt_d && !w_d_err && w_d_load);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tag    <= '0;
      r_starve <= '0;
    end else begin
      r_tag <= w_tag_nxt;
      if (!bus.f_valid || w_gnt_f) r_starve <= '0;
      else if (!w_f_pri)           r_starve <= r_starve + 1'b1;
    end
  end

  // Memory has already lane-selected/extended the data; just steer it to the owner.
  assign bus.f_rvalid = r_tag.vld && r_tag.own_f;
  assign bus.d_rvalid = r_tag.vld && !r_tag.own_f;
  assign bus.f_err    = bus.f_rvalid && r_tag.err;
  assign bus.d_err    = bus.d_rvalid && r_tag.err;
  assign bus.f_rdata  = (bus.f_rvalid && r_tag.load) ? bus.mem_rd_data : '0;
  assign bus.d_rdata  = (bus.d_rvalid && r_tag.load) ? bus.mem_rd_data : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  localparam int MEMB  = 512;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w;
    w = 32'h0A08FFFF;
    if (i >= 4 && i < 8) return w[8*(i-4) +: 8];
    return 8'(i) ^ 8'h5A;
  endfunction

  // Memory read semantics: W word, HZ/BZ zero-extend, HE/BE sign-extend, else 0.
  function automatic logic [31:0] ext(input logic [7:0] b0, b1, b2, b3, input logic [2:0] m);
    case (m)
      3'd0: return {b3, b2, b1, b0};
      3'd1: return {16'h0, b1, b0};
      3'd2: return {24'h0, b0};
      3'd3: return {{16{b1[7]}}, b1, b0};
      3'd4: return {{24{b0[7]}}, b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Memory device: registered read (one-cycle latency), byte-lane writes of low bytes.
  logic [7:0] dev_mem [MEMB];
  initial begin
    for (int i = 0; i < MEMB; i++) dev_mem[i] = init_byte(i);
    bus.mem_rd_data = '0;
    forever begin
      logic [8:0] a;
      @(posedge i_clk);
      a = bus.mem_address[8:0];
      bus.mem_rd_data <= ext(dev_mem[a], dev_mem[9'(a+1)], dev_mem[9'(a+2)], dev_mem[9'(a+3)],
                             bus.mem_rd_mask);
      if (bus.mem_wr_mask != 2'd0)
        for (int k = 0; k < (1 << (bus.mem_wr_mask - 1)); k++)
          dev_mem[9'(a + k)] = bus.mem_wr_data[8*k +: 8];
    end
  end

  // Reference model and per-cycle compare.
  logic [7:0] ref_mem [MEMB];
  initial begin
    int          denied;
    bit          p_vld, p_f, p_err;
    logic [31:0] p_data;
    for (int i = 0; i < MEMB; i++) ref_mem[i] = init_byte(i);
    denied = 0; p_vld = 0; p_f = 0; p_err = 0; p_data = 0;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        chk("rst_f_rvalid", bus.f_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_f_ready",  bus.f_ready, 0);
        chk("rst_d_ready",  bus.d_ready, 0);
        chk("rst_wr_mask",  bus.mem_wr_mask, 0);
        chk("rst_rd_mask",  bus.mem_rd_mask, 5);
        p_vld = 0; denied = 0;
      end else begin
        bit          gd, gf, st, err;
        int          sz;
        logic [8:0]  a;
        logic [31:0] e_addr, e_wd, data;
        logic [1:0]  e_wm;
        logic [2:0]  e_rm;
        chk("f_rvalid", bus.f_rvalid, p_vld && p_f);
        chk("d_rvalid", bus.d_rvalid, p_vld && !p_f);
        if (p_vld && p_f)  begin chk("f_rdata", bus.f_rdata, p_data); chk("f_err", bus.f_err, p_err); end
        if (p_vld && !p_f) begin chk("d_rdata", bus.d_rdata, p_data); chk("d_err", bus.d_err, p_err); end

        gd = bus.d_valid && !(denied == LIMIT && bus.f_valid);
        gf = bus.f_valid && !gd;
        chk("f_ready", bus.f_ready, gf);
        chk("d_ready", bus.d_ready, gd);

        e_addr = 0; e_wd = 0; e_wm = 0; e_rm = 5; err = 0; data = 0; st = 0;
        if (gd) begin
          st = bus.d_wr_mask != 0;
          if (bus.d_rd_mask > 5 || (st && bus.d_rd_mask != 5)) err = 1;
          else begin
            if (st) sz = 1 << (bus.d_wr_mask - 1);
            else case (bus.d_rd_mask) 0: sz = 4; 1, 3: sz = 2; default: sz = 1; endcase
            err = (bus.d_addr % sz) != 0;
          end
          if (!err) begin
            e_addr = bus.d_addr; e_wd = bus.d_wr_data; e_wm = bus.d_wr_mask; e_rm = bus.d_rd_mask;
            a = bus.d_addr[8:0];
            if (!st) data = ext(ref_mem[a], ref_mem[9'(a+1)], ref_mem[9'(a+2)], ref_mem[9'(a+3)],
                                bus.d_rd_mask);
            else for (int k = 0; k < sz; k++) ref_mem[9'(a + k)] = bus.d_wr_data[8*k +: 8];
          end
        end else if (gf) begin
          err = bus.f_addr[1:0] != 0;
          if (!err) begin
            e_addr = bus.f_addr; e_rm = 0;
            a = bus.f_addr[8:0];
            data = ext(ref_mem[a], ref_mem[9'(a+1)], ref_mem[9'(a+2)], ref_mem[9'(a+3)], 3'd0);
          end
        end
        chk("mem_address", bus.mem_address, e_addr);
        chk("mem_wr_data", bus.mem_wr_data, e_wd);
        chk("mem_wr_mask", bus.mem_wr_mask, e_wm);
        chk("mem_rd_mask", bus.mem_rd_mask, e_rm);

        p_vld = gd || gf; p_f = gf; p_err = err; p_data = data;
        if (bus.f_valid && !gf) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
        else denied = 0;
      end
    end
  end

  task automatic idle();
    bus.f_valid = 0; bus.f_addr = 0;
    bus.d_valid = 0; bus.d_addr = 0; bus.d_wr_data = 0; bus.d_wr_mask = 0; bus.d_rd_mask = 5;
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic d_req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wm,
                       input logic [2:0] rm);
    bus.d_valid = 1; bus.d_addr = a; bus.d_wr_data = wd; bus.d_wr_mask = wm; bus.d_rd_mask = rm;
  endtask

  initial begin
    int exp_d [6] = '{1, 1, 1, 1, 0, 1};
    i_reset = 0;
    idle();
    repeat (3) step();
    chk("lit_rst_f_rvalid", bus.f_rvalid, 0);
    chk("lit_rst_d_rvalid", bus.d_rvalid, 0);
    chk("lit_rst_wr_mask", bus.mem_wr_mask, 0);
    chk("lit_rst_rd_mask", bus.mem_rd_mask, 5);
    i_reset = 1;
    step();

    // Fetch 0x04 alone
    bus.f_valid = 1; bus.f_addr = 32'h4;
    #1 chk("lit_f_ready", bus.f_ready, 1);
    step(); idle();
    chk("lit_f_rvalid", bus.f_rvalid, 1);
    chk("lit_f_rdata", bus.f_rdata, 32'h0A08FFFF);

    // Store word, then sign-extended byte load
    d_req(32'h100, 32'hDEADBEEF, 2'd3, 3'd5);
    step(); idle();
    chk("lit_st_rvalid", bus.d_rvalid, 1);
    chk("lit_st_err", bus.d_err, 0);
    d_req(32'h103, 32'h0, 2'd0, 3'd4);
    step(); idle();
    chk("lit_ldbe_rdata", bus.d_rdata, 32'hFFFFFFDE);
    chk("lit_ldbe_err", bus.d_err, 0);

    // Both valid for 6 cycles: D x4, F, D
    bus.f_valid = 1; bus.f_addr = 32'h0;
    d_req(32'h100, 32'h0, 2'd0, 3'd0);
    for (int c = 0; c < 6; c++) begin
      #1 chk("lit_starve_d_ready", bus.d_ready, exp_d[c]);
      chk("lit_starve_f_ready", bus.f_ready, !exp_d[c]);
      step();
    end
    idle(); step();

    // Misaligned half store must not touch memory
    d_req(32'h101, 32'h12345678, 2'd2, 3'd5);
    step(); idle();
    chk("lit_sth_rvalid", bus.d_rvalid, 1);
    chk("lit_sth_err", bus.d_err, 1);
    chk("lit_sth_rdata", bus.d_rdata, 0);
    d_req(32'h100, 32'h0, 2'd0, 3'd0);
    step(); idle();
    chk("lit_reread", bus.d_rdata, 32'hDEADBEEF);

    // Reset between accept and response
    d_req(32'h100, 32'h0, 2'd0, 3'd0);
    @(posedge i_clk); #1;
    i_reset = 0; idle();
    #1 chk("lit_midrst_d_rvalid", bus.d_rvalid, 0);
    step();
    i_reset = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("lit_post_f_rvalid", bus.f_rvalid, 0);
      chk("lit_post_d_rvalid", bus.d_rvalid, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] fa, da;
      logic [1:0]  wm;
      i_reset = ($urandom_range(0, 299) != 0);
      fa = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) fa[1:0] = 2'b00;
      da = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) da[1:0] = 2'b00;
      wm = 2'($urandom_range(0, 3));
      bus.f_valid   = $urandom_range(0, 2) != 0;
      bus.f_addr    = fa;
      bus.d_valid   = $urandom_range(0, 2) != 0;
      bus.d_addr    = da;
      bus.d_wr_data = $urandom;
      bus.d_wr_mask = wm;
      if ($urandom_range(0, 9) == 0)  bus.d_rd_mask = 3'($urandom_range(0, 7));
      else if (wm != 0)               bus.d_rd_mask = 3'd5;
      else                            bus.d_rd_mask = 3'($urandom_range(0, 5));
      step();
    end
    i_reset = 1; idle();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
